// File: rtl/reset_sequencer.sv
// reset_sequencer: lock-qualified staged reset release, oldest output first.
// Optional lock-wait watchdog enabled by defining RST_SEQ_WATCHDOG_EN.
module reset_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int NUM_OUTS    = 3,
   parameter int STAGE_GAP   = 4,
   parameter int WDOG_CYCLES = 1000
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                lock_i,
   input  logic                soft_rst_i,
   output logic [NUM_OUTS-1:0] rst_o,
   output logic [NUM_OUTS-1:0] rst_n_o,
   output logic                ready_o,
   output logic                lock_timeout_o
);
   localparam int MAXC = (HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP) > WDOG_CYCLES ?
                         (HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP) : WDOG_CYCLES;
   localparam int CW = $clog2(MAXC) + 1;
   typedef enum logic [2:0] {ASSERT, WAIT_LOCK, HOLD, RELEASE, RUN} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] run_sync_q, lock_sync_q;
   logic [NUM_OUTS-1:0] rst_q, rst_d, rst_n_q;
   logic ready_q, ready_d, run_s, lock_s, rel;
   assign run_s  = run_sync_q[SYNC_STAGES-1];
   assign lock_s = lock_sync_q[SYNC_STAGES-1];
   // state, counters, synchronizers and registered outputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ASSERT;
         cnt_q       <= '0;
         run_sync_q  <= '0;
         lock_sync_q <= '0;
         rst_q       <= '1;
         rst_n_q     <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         run_sync_q  <= {run_sync_q[SYNC_STAGES-2:0], 1'b1};
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], lock_i};
         rst_q       <= rst_d;
         rst_n_q     <= ~rst_d;
         ready_q     <= ready_d;
      end
   end
   // next state and stage counter; re-assert requests take priority over progress
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         ASSERT:    state_d = run_s ? WAIT_LOCK : ASSERT;
         WAIT_LOCK: state_d = lock_s ? HOLD : WAIT_LOCK;
         HOLD: begin
            state_d = soft_rst_i ? ASSERT : !lock_s ? WAIT_LOCK :
                      cnt_q == CW'(HOLD_CYCLES - 1) ? RELEASE : HOLD;
            cnt_d   = state_d == HOLD ? cnt_q + CW'(1) : '0;
         end
         RELEASE: begin
            state_d = (soft_rst_i || !lock_s) ? ASSERT : rst_q == '0 ? RUN : RELEASE;
            cnt_d   = (state_d == RELEASE && cnt_q != CW'(STAGE_GAP - 1)) ? cnt_q + CW'(1) : '0;
         end
         RUN:     state_d = (soft_rst_i || !lock_s) ? ASSERT : RUN;
         default: state_d = ASSERT;
      endcase
   end
   // release one more output on HOLD exit and every STAGE_GAP cycles in RELEASE
   always_comb begin
      rel     = (state_q == HOLD && state_d == RELEASE) ||
                (state_q == RELEASE && state_d == RELEASE && cnt_q == CW'(STAGE_GAP - 1));
      rst_d   = (state_d == RELEASE || state_d == RUN) ? (rel ? rst_q << 1 : rst_q) : '1;
      ready_d = state_d == RUN;
   end
   assign rst_o   = rst_q;
   assign rst_n_o = rst_n_q;
   assign ready_o = ready_q;
`ifdef RST_SEQ_WATCHDOG_EN
   logic [CW-1:0] wdog_q;
   logic          tout_q;
   // count WAIT_LOCK cycles, saturating; flag is sticky until power-on reset
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wdog_q <= '0;
         tout_q <= 1'b0;
      end else begin
         wdog_q <= state_q != WAIT_LOCK ? '0 : wdog_q == CW'(WDOG_CYCLES - 1) ? wdog_q : wdog_q + CW'(1);
         tout_q <= tout_q | (state_q == WAIT_LOCK && wdog_q == CW'(WDOG_CYCLES - 1));
      end
   end
   assign lock_timeout_o = tout_q;
`else
   assign lock_timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed table-driven bench for reset_sequencer.
module tb_reset_sequencer;
   logic       clk = 1'b0;
   logic       rst_n_i = 1'b0, lock_i = 1'b1, soft_rst_i = 1'b0;
   logic [2:0] rst_o, rst_n_o;
   logic       ready_o, lock_timeout_o;
   int         n_chk = 0, n_fail = 0, edge_n = 0, base;
`ifdef RST_SEQ_WATCHDOG_EN
   localparam logic WD_EXP = 1'b1;
`else
   localparam logic WD_EXP = 1'b0;
`endif
   typedef struct {int edge_n; logic lock; logic [2:0] rstn; logic rdy;} vec_t;
   vec_t cold [8];

   reset_sequencer #(.SYNC_STAGES(2), .HOLD_CYCLES(16), .NUM_OUTS(3), .STAGE_GAP(4), .WDOG_CYCLES(50)) dut (
      .clk_i(clk), .rst_n_i(rst_n_i), .lock_i(lock_i), .soft_rst_i(soft_rst_i),
      .rst_o(rst_o), .rst_n_o(rst_n_o), .ready_o(ready_o), .lock_timeout_o(lock_timeout_o));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
      chk("rst_o_inverse", {29'd0, rst_o}, {29'd0, ~rst_n_o});
   endtask

   task automatic tick_to(input int n);
      while (edge_n < n) tick();
   endtask

   task automatic run_cold();
      for (int i = 0; i < 8; i++) begin
         lock_i = cold[i].lock;
         tick_to(cold[i].edge_n);
         chk("cold_rstn", {29'd0, rst_n_o}, {29'd0, cold[i].rstn});
         chk("cold_ready", {31'd0, ready_o}, {31'd0, cold[i].rdy});
      end
   endtask

   initial begin
      cold[0] = '{1, 1'b1, 3'b000, 1'b0};
      cold[1] = '{19, 1'b1, 3'b000, 1'b0};
      cold[2] = '{20, 1'b1, 3'b001, 1'b0};
      cold[3] = '{23, 1'b1, 3'b001, 1'b0};
      cold[4] = '{24, 1'b1, 3'b011, 1'b0};
      cold[5] = '{27, 1'b1, 3'b011, 1'b0};
      cold[6] = '{28, 1'b1, 3'b111, 1'b0};
      cold[7] = '{29, 1'b1, 3'b111, 1'b1};
      #12;
      chk("reset_rst_o", {29'd0, rst_o}, 32'h7);
      chk("reset_rst_n_o", {29'd0, rst_n_o}, 32'h0);
      chk("reset_ready", {31'd0, ready_o}, 32'h0);
      chk("reset_timeout", {31'd0, lock_timeout_o}, 32'h0);
      tick();
      rst_n_i = 1'b1;
      edge_n = 0;
      run_cold();
      // soft reset in RUN
      soft_rst_i = 1'b1;
      tick();
      soft_rst_i = 1'b0;
      base = edge_n;
      chk("soft_rst_o", {29'd0, rst_o}, 32'h7);
      chk("soft_ready", {31'd0, ready_o}, 32'h0);
      tick_to(base + 17);
      chk("soft_rstn_pre", {29'd0, rst_n_o}, 32'h0);
      tick_to(base + 18);
      chk("soft_rstn_first", {29'd0, rst_n_o}, 32'h1);
      tick_to(base + 26);
      chk("soft_ready_pre", {31'd0, ready_o}, 32'h0);
      tick_to(base + 27);
      chk("soft_ready", {31'd0, ready_o}, 32'h1);
      // lock glitch during HOLD
      soft_rst_i = 1'b1;
      tick();
      soft_rst_i = 1'b0;
      base = edge_n;
      tick_to(base + 4);
      lock_i = 1'b0;
      tick_to(base + 7);
      lock_i = 1'b1;
      tick_to(base + 18);
      chk("glitch_no_early", {29'd0, rst_n_o}, 32'h0);
      tick_to(base + 25);
      chk("glitch_rstn_pre", {29'd0, rst_n_o}, 32'h0);
      tick_to(base + 26);
      chk("glitch_rstn_first", {29'd0, rst_n_o}, 32'h1);
      tick_to(base + 35);
      chk("glitch_ready", {31'd0, ready_o}, 32'h1);
      // lock loss in RUN
      base = edge_n;
      lock_i = 1'b0;
      tick_to(base + 2);
      chk("loss_still_run", {29'd0, rst_n_o}, 32'h7);
      tick_to(base + 3);
      chk("loss_rstn", {29'd0, rst_n_o}, 32'h0);
      chk("loss_ready", {31'd0, ready_o}, 32'h0);
      lock_i = 1'b1;
      tick_to(base + 21);
      chk("relock_rstn_pre", {29'd0, rst_n_o}, 32'h0);
      tick_to(base + 22);
      chk("relock_rstn_first", {29'd0, rst_n_o}, 32'h1);
      // asynchronous reset mid-RELEASE
      #3;
      rst_n_i = 1'b0;
      #1;
      chk("async_rst_o", {29'd0, rst_o}, 32'h7);
      chk("async_rst_n_o", {29'd0, rst_n_o}, 32'h0);
      chk("async_ready", {31'd0, ready_o}, 32'h0);
      tick();
      tick();
      rst_n_i = 1'b1;
      edge_n = 0;
      run_cold();
      // lock-wait watchdog
      rst_n_i = 1'b0;
      lock_i = 1'b0;
      tick();
      rst_n_i = 1'b1;
      edge_n = 0;
      tick_to(52);
      chk("wdog_pre", {31'd0, lock_timeout_o}, 32'h0);
      chk("wdog_waiting", {29'd0, rst_n_o}, 32'h0);
      tick_to(53);
      chk("wdog_flag", {31'd0, lock_timeout_o}, {31'd0, WD_EXP});
      lock_i = 1'b1;
      tick_to(71);
      chk("wdog_rstn_pre", {29'd0, rst_n_o}, 32'h0);
      tick_to(72);
      chk("wdog_rstn_first", {29'd0, rst_n_o}, 32'h1);
      tick_to(81);
      chk("wdog_ready", {31'd0, ready_o}, 32'h1);
      chk("wdog_sticky", {31'd0, lock_timeout_o}, {31'd0, WD_EXP});
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

- Consumes the raw testbench/board reset (`rst_n_i`) and a PLL lock indication.
- Produces a staged, synchronously deasserted reset bundle for the image BRAM datapath.
- Assertion is immediate and asynchronous; deassertion follows a lock-qualified hold period, then releases each output one at a time, oldest index first.
- Sits directly downstream of the clock/reset generator and upstream of every consumer of `rst_o`/`rst_n_o`.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for reset release and `lock_i`; must be ≥2.
- `HOLD_CYCLES`, 16: cycles lock must be stable before the first release; must be ≥1.
- `NUM_OUTS`, 3: number of reset outputs; must be ≥1.
- `STAGE_GAP`, 4: cycles between successive output releases; must be ≥1.
- `WDOG_CYCLES`, 1000: lock-wait watchdog limit; used only with `RST_SEQ_WATCHDOG_EN`.

Ports:
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `lock_i` in 1: PLL lock, asynchronous to `clk_i`.
- `soft_rst_i` in 1: synchronous re-sequence request, sampled each edge.
- `rst_o` out NUM_OUTS: active-high resets.
- `rst_n_o` out NUM_OUTS: bitwise inverse of `rst_o`, registered, never skewed from `rst_o`.
- `ready_o` out 1: all outputs released.
- `lock_timeout_o` out 1: sticky watchdog flag.

## Operation
- `rst_n_i` low, asynchronously: `rst_o`=all 1, `rst_n_o`=all 0, `ready_o`=0, `lock_timeout_o`=0, state ASSERT, all counters and synchronizer flops 0.
- Reset release: `rst_n_i` passes through a `SYNC_STAGES` flop chain (async clear, D=1) to form `run_s`. `lock_i` passes through its own `SYNC_STAGES` chain to form `lock_s`.
- FSM states and transitions:
  - ASSERT: all outputs asserted; go to WAIT_LOCK when `run_s`=1.
  - WAIT_LOCK: go to HOLD when `lock_s`=1; clear the hold counter on entry.
  - HOLD: count cycles. If `lock_s`=0, go to WAIT_LOCK with outputs still asserted. At count=`HOLD_CYCLES`-1, go to RELEASE and deassert output 0 on that same edge.
  - RELEASE: deassert output k exactly `STAGE_GAP` cycles after output k-1. One cycle after the last output is deasserted, go to RUN and set `ready_o`=1.
  - RUN: hold all outputs deasserted.
- Re-assert triggers:
  - `soft_rst_i`=1 in HOLD, RELEASE or RUN → ASSERT on the next edge.
  - `lock_s`=0 in RELEASE or RUN → ASSERT on the next edge.
  - On that edge: all `rst_o`=1 and `ready_o`=0 simultaneously.
  - ASSERT then lasts one cycle (`run_s` is already 1).
- `soft_rst_i` in ASSERT or WAIT_LOCK: ignored.
- Simultaneous `soft_rst_i` and lock loss: ASSERT, counted once.
- Release order is fixed: index 0 first.
- Counter width: `$clog2` of the maximum of `HOLD_CYCLES`, `STAGE_GAP` and `WDOG_CYCLES`, plus 1. Counters never wrap.

## Timing
Cold start (edges counted after `rst_n_i` rises, `lock_i` steady high, S=`SYNC_STAGES`, H=`HOLD_CYCLES`, G=`STAGE_GAP`):
- `run_s` and `lock_s` high at edge S; WAIT_LOCK at S+1; HOLD at S+2.
- `rst_n_o[k]` rises at edge S+2+H+k·G.
- `ready_o` rises at edge S+2+H+(NUM_OUTS-1)·G+1.
- With defaults: `rst_n_o` = edges 20/24/28, `ready_o` = edge 29.

Soft reset sampled at edge E:
- Outputs asserted at E; WAIT_LOCK at E+1; HOLD at E+2.
- `rst_n_o[0]` at E+2+H (E+18 with defaults).

Lock-loss latency:
- `lock_i` falling to `lock_s`=0 takes S edges.
- Outputs assert on the following edge.

Reset mid-operation: `rst_n_i` low in any state returns all outputs to their reset values within the same delta, no clock required.

## Configuration
Macro `RST_SEQ_WATCHDOG_EN`:
- Defined:
  - A watchdog counts cycles spent in WAIT_LOCK.
  - On reaching `WDOG_CYCLES`, `lock_timeout_o` is set to 1 and stays 1 until `rst_n_i` is low.
  - The FSM remains in WAIT_LOCK. The watchdog counter clears when WAIT_LOCK is exited.
- Undefined: `lock_timeout_o` is tied 0 and no watchdog logic is present.

## Test plan
- Cold start with defaults, `lock_i`=1: `rst_n_o` bits rise at edges 20/24/28, `ready_o` at 29, and `rst_o`==~`rst_n_o` throughout.
- `lock_i` pulsed low for 3 cycles while in HOLD: state returns to WAIT_LOCK, and the release happens H+2+S-aligned cycles after lock recovers. No output toggles early.
- 1-cycle `soft_rst_i` in RUN at edge E: `rst_o`=3'b111 and `ready_o`=0 at E; `rst_n_o[0]` rises at E+18.
- `lock_i` dropped in RUN: all outputs reasserted at S+1 edges after the fall; re-release when lock returns.
- `rst_n_i` asserted mid-RELEASE (after `rst_n_o[0]` high): all outputs reset immediately with no clock edge; the sequence restarts from edge 0 after release.
- With `RST_SEQ_WATCHDOG_EN` and `WDOG_CYCLES`=50, `lock_i`=0: `lock_timeout_o`=1 after 50 WAIT_LOCK cycles, and it stays 1 after lock arrives and sequencing completes.
